jtcomsc_snd_comm: RTL and testbench

// Main-to-sound CPU mailbox fed by the main decoder outputs snd_latch/snd_irq.
// - Each snd_irq rising edge pushes snd_latch into a small FIFO.
// - Drives the sound Z80 /INT line while data is pending, clears it on interrupt acknowledge.
// - Gives the sound CPU data and status read ports, so back-to-back commands are not lost.

---
 rtl/jtcomsc_snd_comm.sv | 117 +++++++++++
 tb/tb_jtcomsc_snd_comm.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtcomsc_snd_comm.sv
// jtcomsc_snd_comm: main-to-sound CPU command mailbox.
// Queues snd_latch on each snd_irq rising edge and drives the sound Z80 /INT line.
`default_nettype none

module jtcomsc_snd_comm #(
    parameter int AW = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] snd_latch,
    input  logic       snd_irq,
    input  logic       snd_cen,
    input  logic       snd_m1_n,
    input  logic       snd_iorq_n,
    input  logic       rd_cs,
    input  logic       rd_addr,
    output logic [7:0] snd_dout,
    output logic       snd_int_n,
    output logic       ovf
);
    localparam int            DEPTH    = 1 << AW;
    localparam logic [AW:0]   FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [7:0]    hold;
    logic          armed;
    logic          irq_l;
    logic          rd_l;
    logic          addr_l;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          do_wr;
    logic          ovf_set;
    logic          stat_end;
    logic          ack;
    logic [7:0]    status;

    always_comb begin
        empty    = (count == '0);
        full     = (count == FULL_CNT);
        push     = snd_irq & ~irq_l;
        pop      = rd_l & ~rd_cs & ~addr_l & ~empty;
        // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
        do_wr    = push & (~full | pop);
        ovf_set  = push & full & ~pop;
        stat_end = rd_l & ~rd_cs & addr_l;
        ack      = snd_cen & ~snd_m1_n & ~snd_iorq_n;
        status   = {ovf, empty, full, 5'(count)};
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= snd_latch;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_l  <= 1'b0;
            rd_l   <= 1'b0;
            addr_l <= 1'b0;
        end else begin
            irq_l <= snd_irq;
            rd_l  <= rd_cs;
            if (rd_cs) addr_l <= rd_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= 8'hff;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
                hold   <= mem[rd_ptr];
            end
            case ({do_wr, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Re-arming has priority over an acknowledge so a new command is never hidden.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed     <= 1'b1;
            snd_int_n <= 1'b1;
            ovf       <= 1'b0;
        end else begin
            if (pop || (push && empty)) armed <= 1'b1;
            else if (ack)               armed <= 1'b0;
            snd_int_n <= ~(armed & ~empty);
            if (ovf_set)       ovf <= 1'b1;
            else if (stat_end) ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst)          snd_dout <= 8'hff;
        else if (!rd_cs)  snd_dout <= 8'hff;
        else if (rd_addr) snd_dout <= status;
        else              snd_dout <= empty ? hold : mem[rd_ptr];
    end

endmodule

`default_nettype wire

// File: tb/tb_jtcomsc_snd_comm.sv
// tb_jtcomsc_snd_comm: self-checking bench for the sound mailbox.
// A transaction-level queue model predicts data, status and /INT.
`default_nettype none

module tb_jtcomsc_snd_comm;
    localparam int AW    = 2;
    localparam int DEPTH = 1 << AW;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] snd_latch = 8'h00;
    logic       snd_irq = 1'b0;
    logic       snd_cen = 1'b0;
    logic       snd_m1_n = 1'b1;
    logic       snd_iorq_n = 1'b1;
    logic       rd_cs = 1'b0;
    logic       rd_addr = 1'b0;
    logic [7:0] snd_dout;
    logic       snd_int_n;
    logic       ovf;

    int total = 0;
    int bad   = 0;

    // reference model
    logic [7:0] q[$];
    logic       m_ovf;
    logic [7:0] m_hold;
    logic       m_armed;

    jtcomsc_snd_comm #(.AW(AW)) dut (
        .clk(clk), .rst(rst), .snd_latch(snd_latch), .snd_irq(snd_irq),
        .snd_cen(snd_cen), .snd_m1_n(snd_m1_n), .snd_iorq_n(snd_iorq_n),
        .rd_cs(rd_cs), .rd_addr(rd_addr), .snd_dout(snd_dout),
        .snd_int_n(snd_int_n), .ovf(ovf)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_status();
        int n = q.size();
        return {m_ovf, n == 0, n == DEPTH, 5'(n)};
    endfunction

    function automatic logic [7:0] exp_data();
        return (q.size() != 0) ? q[0] : m_hold;
    endfunction

    function automatic logic exp_int_n();
        return ~(m_armed && q.size() != 0);
    endfunction

    task automatic model_reset();
        q.delete();
        m_ovf   = 1'b0;
        m_hold  = 8'hff;
        m_armed = 1'b1;
    endtask

    task automatic model_push(input logic [7:0] b);
        if (q.size() < DEPTH) begin
            if (q.size() == 0) m_armed = 1'b1;
            q.push_back(b);
        end else begin
            m_ovf = 1'b1;
        end
    endtask

    task automatic model_end_read(input logic a);
        if (!a && q.size() != 0) begin
            m_hold  = q.pop_front();
            m_armed = 1'b1;
        end else if (a) begin
            m_ovf = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
    endtask

    task automatic push_byte(input logic [7:0] b);
        @(negedge clk);
        snd_latch = b;
        snd_irq   = 1'b1;
        @(negedge clk);
        snd_irq = 1'b0;
        model_push(b);
        @(negedge clk);
    endtask

    // Read cycle; if with_push, a new command edge lands in the read-end clock.
    task automatic read_port(input logic a, input logic with_push, input logic [7:0] pb,
                             output logic [7:0] got, output logic [7:0] expv);
        expv = a ? exp_status() : exp_data();
        @(negedge clk);
        rd_cs   = 1'b1;
        rd_addr = a;
        @(negedge clk);
        got = snd_dout;
        rd_cs = 1'b0;
        if (with_push) begin
            snd_latch = pb;
            snd_irq   = 1'b1;
        end
        @(negedge clk);
        snd_irq = 1'b0;
        model_end_read(a);
        if (with_push) model_push(pb);
        @(negedge clk);
    endtask

    task automatic do_ack();
        @(negedge clk);
        snd_cen    = 1'b1;
        snd_m1_n   = 1'b0;
        snd_iorq_n = 1'b0;
        @(negedge clk);
        snd_cen    = 1'b0;
        snd_m1_n   = 1'b1;
        snd_iorq_n = 1'b1;
        m_armed    = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        total++;
        if (snd_int_n !== 1'b1 || ovf !== 1'b0 || snd_dout !== 8'hff) begin
            bad++;
            $display("FAIL reset: int_n=%b ovf=%b dout=%h required 1 0 ff", snd_int_n, ovf, snd_dout);
        end
    endtask

    task automatic test_basic();
        logic [7:0] got, expv;
        push_byte(8'h5a);
        total++;
        if (snd_int_n !== 1'b0) begin
            bad++; $display("FAIL basic_int: int_n=%b required 0", snd_int_n);
        end
        read_port(1'b1, 1'b0, 8'h00, got, expv);
        total++;
        if (got !== expv || expv !== 8'h01) begin
            bad++; $display("FAIL basic_status: got %h model %h required 01", got, expv);
        end
        do_ack();
        total++;
        if (snd_int_n !== 1'b1) begin
            bad++; $display("FAIL basic_ack: int_n=%b required 1", snd_int_n);
        end
        read_port(1'b0, 1'b0, 8'h00, got, expv);
        total++;
        if (got !== 8'h5a) begin
            bad++; $display("FAIL basic_data: got %h required 5a", got);
        end
        read_port(1'b0, 1'b0, 8'h00, got, expv);
        total++;
        if (got !== 8'h5a) begin
            bad++; $display("FAIL basic_hold: got %h required 5a", got);
        end
        read_port(1'b1, 1'b0, 8'h00, got, expv);
        total++;
        if (got !== 8'h40) begin
            bad++; $display("FAIL basic_empty: got %h required 40", got);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] got, expv;
        for (int i = 1; i <= 5; i++) push_byte(8'(i));
        total++;
        if (ovf !== 1'b1) begin
            bad++; $display("FAIL ovf_flag: ovf=%b required 1", ovf);
        end
        read_port(1'b1, 1'b0, 8'h00, got, expv);
        total++;
        if (got !== 8'ha4) begin
            bad++; $display("FAIL ovf_status: got %h required a4", got);
        end
        total++;
        if (ovf !== 1'b0) begin
            bad++; $display("FAIL ovf_clear: ovf=%b required 0", ovf);
        end
        for (int i = 1; i <= 4; i++) begin
            read_port(1'b0, 1'b0, 8'h00, got, expv);
            total++;
            if (got !== 8'(i)) begin
                bad++; $display("FAIL ovf_data%0d: got %h required %h", i, got, 8'(i));
            end
        end
    endtask

    task automatic test_push_pop_full();
        logic [7:0] got, expv;
        logic [7:0] order [4] = '{8'h02, 8'h03, 8'h04, 8'h99};
        for (int i = 1; i <= 4; i++) push_byte(8'(i));
        read_port(1'b0, 1'b1, 8'h99, got, expv);
        total++;
        if (got !== 8'h01) begin
            bad++; $display("FAIL pp_first: got %h required 01", got);
        end
        total++;
        if (ovf !== 1'b0) begin
            bad++; $display("FAIL pp_ovf: ovf=%b required 0", ovf);
        end
        read_port(1'b1, 1'b0, 8'h00, got, expv);
        total++;
        if (got !== 8'h24) begin
            bad++; $display("FAIL pp_status: got %h required 24", got);
        end
        for (int i = 0; i < 4; i++) begin
            read_port(1'b0, 1'b0, 8'h00, got, expv);
            total++;
            if (got !== order[i]) begin
                bad++; $display("FAIL pp_order%0d: got %h required %h", i, got, order[i]);
            end
        end
    endtask

    task automatic test_int_rearm();
        logic [7:0] got, expv;
        do_reset();
        push_byte(8'h11);
        push_byte(8'h22);
        do_ack();
        total++;
        if (snd_int_n !== 1'b1) begin
            bad++; $display("FAIL rearm_ack: int_n=%b required 1", snd_int_n);
        end
        read_port(1'b0, 1'b0, 8'h00, got, expv);
        total++;
        if (snd_int_n !== 1'b0 || got !== 8'h11) begin
            bad++; $display("FAIL rearm_pop: int_n=%b data=%h required 0 11", snd_int_n, got);
        end
        do_ack();
        read_port(1'b0, 1'b0, 8'h00, got, expv);
        total++;
        if (snd_int_n !== 1'b1 || got !== 8'h22) begin
            bad++; $display("FAIL rearm_last: int_n=%b data=%h required 1 22", snd_int_n, got);
        end
    endtask

    task automatic test_reset_mid();
        logic [7:0] got, expv;
        for (int i = 0; i < 3; i++) push_byte(8'h30 + 8'(i));
        total++;
        if (snd_int_n !== 1'b0) begin
            bad++; $display("FAIL mid_pre: int_n=%b required 0", snd_int_n);
        end
        @(negedge clk);
        rst       = 1'b1;
        snd_latch = 8'h77;
        snd_irq   = 1'b1;
        @(negedge clk);
        total++;
        if (snd_int_n !== 1'b1 || ovf !== 1'b0) begin
            bad++; $display("FAIL mid_rst: int_n=%b ovf=%b required 1 0", snd_int_n, ovf);
        end
        repeat (2) @(negedge clk);
        snd_irq = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        read_port(1'b1, 1'b0, 8'h00, got, expv);
        total++;
        if (got !== 8'h40) begin
            bad++; $display("FAIL mid_status: got %h required 40", got);
        end
        read_port(1'b0, 1'b0, 8'h00, got, expv);
        total++;
        if (got !== 8'hff) begin
            bad++; $display("FAIL mid_hold: got %h required ff", got);
        end
    endtask

    task automatic test_random();
        logic [7:0] got, expv;
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 3))
                0, 1: push_byte(8'($urandom));
                2: begin
                    read_port(1'($urandom_range(0, 1)), 1'b0, 8'h00, got, expv);
                    total++;
                    if (got !== expv) begin
                        bad++; $display("FAIL rnd_read%0d: got %h required %h", n, got, expv);
                    end
                end
                default: do_ack();
            endcase
            total++;
            if (snd_int_n !== exp_int_n() || ovf !== m_ovf) begin
                bad++;
                $display("FAIL rnd_state%0d: int_n=%b ovf=%b required %b %b",
                         n, snd_int_n, ovf, exp_int_n(), m_ovf);
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_basic();
        test_overflow();
        test_push_pop_full();
        test_int_rearm();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
